lector_rtc: RTL

Upstream feeder of the VGA display stage. Periodically reads the nine time registers of the RTC over its multiplexed address/data bus, collects them in shadow registers, and commits them atomically to the nine BCD outputs during vertical sync so the display never shows a half-updated frame. Provides the DIA_T…SEGUNDOT_T bytes consumed by the display stage.

---
 rtl/lector_rtc_pkg.sv | 34 +++
 rtl/lector_rtc_if.sv | 23 ++
 rtl/lector_rtc_fase_ctr.sv | 34 +++
 rtl/lector_rtc.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lector_rtc_pkg.sv
// Shared types and constants for the RTC time reader: FSM states, RTC register
// addresses in burst order and the burst-index to output-byte mapping.
package lector_rtc_pkg;

   localparam int unsigned NUM_REGS = 9;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned PH_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP_A,
      ST_DATA,
      ST_GAP_D,
      ST_COMMIT
   } state_t;

   // RTC address read at each burst index
   localparam logic [BYTE_W-1:0] REG_ADDR [NUM_REGS] = '{
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
   };

   localparam logic [IDX_W-1:0] IDX_SEGUNDO  = 4'd0;
   localparam logic [IDX_W-1:0] IDX_MINUTO   = 4'd1;
   localparam logic [IDX_W-1:0] IDX_HORA     = 4'd2;
   localparam logic [IDX_W-1:0] IDX_DIA      = 4'd3;
   localparam logic [IDX_W-1:0] IDX_MES      = 4'd4;
   localparam logic [IDX_W-1:0] IDX_ANO      = 4'd5;
   localparam logic [IDX_W-1:0] IDX_SEGUNDOT = 4'd6;
   localparam logic [IDX_W-1:0] IDX_MINUTOT  = 4'd7;
   localparam logic [IDX_W-1:0] IDX_HORAT    = 4'd8;

endpackage

// File: rtl/lector_rtc_if.sv
// Multiplexed RTC address/data bus; the reader is the master.
interface lector_rtc_if;
   import lector_rtc_pkg::*;

   logic [BYTE_W-1:0] ad_in;
   logic [BYTE_W-1:0] ad_out;
   logic              ad_oe;
   logic              ad_sel;
   logic              cs_n;
   logic              rd_n;
   logic              wr_n;

   modport master (
      input  ad_in,
      output ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
   );

   modport slave (
      output ad_in,
      input  ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
   );

endinterface

// File: rtl/lector_rtc_fase_ctr.sv
// Bus phase timer: cleared by load_i, flags the last clock of a PHASE_CYCLES phase.
module bus_fase_ctr
   import lector_rtc_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expire_c_o
);

   logic [PH_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + PH_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_c_o = (cnt_q == PH_W'(PHASE_CYCLES - 1));

endmodule

// File: rtl/lector_rtc.sv
// Periodic RTC time reader: bursts nine register reads into shadows and copies
// them to the BCD outputs in one clock during vertical sync.
module lector_rtc
   import lector_rtc_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES   = 4,
   parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vs_i,
   input  logic              hold_i,
   lector_rtc_if.master      bus,
   output logic              busy_o,
   output logic [BYTE_W-1:0] dia_t_o,
   output logic [BYTE_W-1:0] mes_t_o,
   output logic [BYTE_W-1:0] ano_t_o,
   output logic [BYTE_W-1:0] hora_t_o,
   output logic [BYTE_W-1:0] minuto_t_o,
   output logic [BYTE_W-1:0] segundo_t_o,
   output logic [BYTE_W-1:0] horat_t_o,
   output logic [BYTE_W-1:0] minutot_t_o,
   output logic [BYTE_W-1:0] segundot_t_o
);

   localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);

   state_t             state_q, state_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BYTE_W-1:0]  shadow_q [NUM_REGS];
   logic [BYTE_W-1:0]  out_q    [NUM_REGS];
   logic [BYTE_W-1:0]  ad_out_q, ad_out_d;
   logic               ad_oe_q, ad_oe_d;
   logic               ad_sel_q, ad_sel_d;
   logic               cs_n_q, cs_n_d;
   logic               rd_n_q, rd_n_d;
   logic               wr_n_q, wr_n_d;
   logic               busy_q, busy_d;
   logic               phase_done_c, ref_done_c, load_c;
   logic               capture_c, commit_c;

   bus_fase_ctr #(.PHASE_CYCLES(PHASE_CYCLES)) u_fase_ctr (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load_c),
      .expire_c_o(phase_done_c)
   );

   assign ref_done_c = (ref_q == REF_W'(REFRESH_CYCLES - 1));
   assign load_c     = (state_d != state_q);

   // Next state; bus strobes are decoded from the next state so they register in step with it
   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      idx_d     = idx_q;
      capture_c = 1'b0;
      commit_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!ref_done_c) begin
               ref_d = ref_q + REF_W'(1);
            end else if (!hold_i) begin
               state_d = ST_ADDR;
               idx_d   = '0;
               ref_d   = '0;
            end
         end
         ST_ADDR:  if (phase_done_c) state_d = ST_GAP_A;
         ST_GAP_A: if (phase_done_c) state_d = ST_DATA;
         ST_DATA: begin
            if (phase_done_c) begin
               capture_c = 1'b1;
               state_d   = ST_GAP_D;
            end
         end
         ST_GAP_D: begin
            if (phase_done_c) begin
               if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                  state_d = ST_COMMIT;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_ADDR;
               end
            end
         end
         ST_COMMIT: begin
            if (!vs_i) begin
               commit_c = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ad_oe_d  = (state_d == ST_ADDR);
      ad_sel_d = (state_d == ST_DATA);
      cs_n_d   = !((state_d == ST_ADDR) || (state_d == ST_DATA));
      wr_n_d   = (state_d != ST_ADDR);
      rd_n_d   = (state_d != ST_DATA);
      ad_out_d = (state_d == ST_ADDR) ? REG_ADDR[idx_d] : '0;
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ref_q    <= '0;
         idx_q    <= '0;
         ad_out_q <= '0;
         ad_oe_q  <= 1'b0;
         ad_sel_q <= 1'b0;
         cs_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         idx_q    <= idx_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         ad_sel_q <= ad_sel_d;
         cs_n_q   <= cs_n_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
         busy_q   <= busy_d;
      end
   end

   // Shadows fill one byte per read; outputs take all nine together on commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= '0;
            out_q[i]    <= '0;
         end
      end else begin
         if (capture_c) begin
            shadow_q[idx_q] <= bus.ad_in;
         end
         if (commit_c) begin
            out_q <= shadow_q;
         end
      end
   end

   assign bus.ad_out   = ad_out_q;
   assign bus.ad_oe    = ad_oe_q;
   assign bus.ad_sel   = ad_sel_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.rd_n     = rd_n_q;
   assign bus.wr_n     = wr_n_q;
   assign busy_o       = busy_q;

   assign segundo_t_o  = out_q[IDX_SEGUNDO];
   assign minuto_t_o   = out_q[IDX_MINUTO];
   assign hora_t_o     = out_q[IDX_HORA];
   assign dia_t_o      = out_q[IDX_DIA];
   assign mes_t_o      = out_q[IDX_MES];
   assign ano_t_o      = out_q[IDX_ANO];
   assign segundot_t_o = out_q[IDX_SEGUNDOT];
   assign minutot_t_o  = out_q[IDX_MINUTOT];
   assign horat_t_o    = out_q[IDX_HORAT];

endmodule
